// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use interlock, deferred flush and saturating perf counters.
// One-cycle ID->EX latency; ex_hold freezes the register and stall_id holds PC and IF/ID.
module id_ex_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [15:0]      id_ctrl,
  input  logic [31:0]      id_rd1,
  input  logic [31:0]      id_rd2,
  input  logic [31:0]      id_imm,
  input  logic             ex_hold,
  input  logic             flush,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [15:0]      ex_ctrl,
  output logic [31:0]      ex_rd1,
  output logic [31:0]      ex_rd2,
  output logic [31:0]      ex_imm,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] WD_MEM = 2'b01;

  logic flush_pend;
  logic ld_use;
  logic eff_flush;
  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // A load in EX whose destination feeds the ID instruction needs one bubble.
  assign ex_is_load = ex_valid & ex_ctrl[15] & (ex_ctrl[12:11] == WD_MEM) & (ex_rd != 5'd0);
  assign rs1_hit    = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit    = id_use_rs2 & (id_rs2 == ex_rd);
  assign ld_use     = id_valid & ex_is_load & (rs1_hit | rs2_hit);

  // A flush seen while held is remembered and applied on the first unheld edge.
  assign eff_flush  = (flush | flush_pend) & ~ex_hold;
  assign stall_id   = ex_hold | (ld_use & ~eff_flush);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      flush_pend <= 1'b0;
    end else if (ex_hold) begin
      if (flush) flush_pend <= 1'b1;
    end else if (eff_flush || ld_use) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      ex_rd    <= '0;
      ex_ctrl  <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      if (eff_flush) begin
        flush_pend <= 1'b0;
        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end else begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      ex_rd    <= id_rd;
      ex_ctrl  <= id_valid ? id_ctrl : 16'h0000;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with small counters so saturation is reachable.
module tb_id_ex_stage;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2;
  logic [15:0]   id_ctrl;
  logic [31:0]   id_rd1, id_rd2, id_imm;
  logic          ex_hold, flush;
  logic          stall_id;
  logic          ex_valid;
  logic [31:0]   ex_pc;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [15:0]   ex_ctrl;
  logic [31:0]   ex_rd1, ex_rd2, ex_imm;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  id_ex_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_ctrl(id_ctrl),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .ex_hold(ex_hold), .flush(flush), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                        input logic u2, input logic [15:0] ctrl);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_ctrl = ctrl;
    id_rd1 = pc ^ 32'hAAAA_0000; id_rd2 = pc ^ 32'h5555_0000; id_imm = pc + 32'd4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; ex_hold = 1'b1; flush = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0);
    #2;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_pc", ex_pc, 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_stall_eq_hold", 32'(stall_id), 32'd1);
    ex_hold = 1'b0;
    #1;
    chk("rst_stall_nohold", 32'(stall_id), 32'd0);

    // pass-through of an add
    set_id(1'b1, 32'h100, 5'd2, 5'd3, 5'd1, 1'b0, 1'b0, 16'h8018);
    #4 rstn = 1'b1;
    tick();
    chk("pt_pc", ex_pc, 32'h100);
    chk("pt_ctrl", 32'(ex_ctrl), 32'h8018);
    chk("pt_valid", 32'(ex_valid), 32'd1);
    chk("pt_rd1", ex_rd1, 32'hAAAA_0100);
    chk("pt_imm", ex_imm, 32'h104);
    chk("pt_stall", 32'(stall_id), 32'd0);

    // load-use on rs1
    set_id(1'b1, 32'h104, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 16'hA818);
    tick();
    chk("lu_lw_ctrl", 32'(ex_ctrl), 32'hA818);
    set_id(1'b1, 32'h108, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 16'h8018);
    #1;
    chk("lu_stall", 32'(stall_id), 32'd1);
    tick();
    chk("lu_bub_valid", 32'(ex_valid), 32'd0);
    chk("lu_bub_ctrl", 32'(ex_ctrl), 32'd0);
    chk("lu_bub_pc", ex_pc, 32'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_stall_after", 32'(stall_id), 32'd0);
    tick();
    chk("lu_enter_pc", ex_pc, 32'h108);
    chk("lu_enter_valid", 32'(ex_valid), 32'd1);

    // zero register never interlocks
    set_id(1'b1, 32'h10C, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 16'hA818);
    tick();
    set_id(1'b1, 32'h110, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 16'h8018);
    #1;
    chk("zr_stall", 32'(stall_id), 32'd0);
    tick();
    chk("zr_pc", ex_pc, 32'h110);
    chk("zr_cnt", 32'(stall_cnt), 32'd1);

    // flush wins over load-use (via rs2)
    set_id(1'b1, 32'h114, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, 16'hA818);
    tick();
    set_id(1'b1, 32'h118, 5'd0, 5'd7, 5'd8, 1'b0, 1'b1, 16'h8018);
    flush = 1'b1;
    #1;
    chk("fl_stall", 32'(stall_id), 32'd0);
    tick();
    flush = 1'b0;
    chk("fl_bub_valid", 32'(ex_valid), 32'd0);
    chk("fl_cnt", 32'(flush_cnt), 32'd1);
    chk("fl_stall_cnt", 32'(stall_cnt), 32'd1);
    tick();
    chk("fl_next_pc", ex_pc, 32'h118);

    // flush pulse during a two-cycle hold is deferred
    set_id(1'b1, 32'h11C, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 16'h8018);
    ex_hold = 1'b1; flush = 1'b1;
    #1;
    chk("hd_stall", 32'(stall_id), 32'd1);
    tick();
    flush = 1'b0;
    chk("hd_pc1", ex_pc, 32'h118);
    chk("hd_cnt1", 32'(flush_cnt), 32'd1);
    tick();
    chk("hd_pc2", ex_pc, 32'h118);
    ex_hold = 1'b0;
    #1;
    chk("hd_release_stall", 32'(stall_id), 32'd0);
    tick();
    chk("hd_bub_valid", 32'(ex_valid), 32'd0);
    chk("hd_bub_pc", ex_pc, 32'd0);
    chk("hd_cnt2", 32'(flush_cnt), 32'd2);
    tick();
    chk("hd_load_pc", ex_pc, 32'h11C);
    chk("hd_load_valid", 32'(ex_valid), 32'd1);

    // invalid ID slot: fields copied, ctrl zeroed
    set_id(1'b0, 32'h120, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 16'h8018);
    tick();
    chk("nv_valid", 32'(ex_valid), 32'd0);
    chk("nv_ctrl", 32'(ex_ctrl), 32'd0);
    chk("nv_pc", ex_pc, 32'h120);
    chk("nv_rd", 32'(ex_rd), 32'd5);

    // stall counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      set_id(1'b1, 32'h200 + 32'(k * 16), 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 16'hA818);
      tick();
      set_id(1'b1, 32'h204 + 32'(k * 16), 5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 16'h8018);
      tick();
      chk("sat_cnt", 32'(stall_cnt), (k == 0) ? 32'd2 : 32'd3);
      tick();
    end

    // reset mid-hold discards pending flush
    set_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 16'h8018);
    tick();
    ex_hold = 1'b1; flush = 1'b1;
    tick();
    ex_hold = 1'b0; flush = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("ar_valid", 32'(ex_valid), 32'd0);
    chk("ar_pc", ex_pc, 32'd0);
    chk("ar_ctrl", 32'(ex_ctrl), 32'd0);
    chk("ar_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("ar_flush_cnt", 32'(flush_cnt), 32'd0);
    #1 rstn = 1'b1;
    set_id(1'b1, 32'h304, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 16'h8018);
    tick();
    chk("ar_after_pc", ex_pc, 32'h304);
    chk("ar_after_valid", 32'(ex_valid), 32'd1);
    chk("ar_after_fcnt", 32'(flush_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
